// File: rtl/tone_gen_pkg.sv
// Shared audio constants: default divisor width and tone FSM state encodings.
// Used by tone_gen and by the upstream note lookup.
package tone_gen_pkg;

    localparam int unsigned DIV_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StStop = 2'd2
    } state_e;

endpackage

// File: rtl/tone_gen.sv
// Square-wave tone generator: half-period of div clk cycles, divisor sampled at
// half-period boundaries, stop requests honoured at the next boundary.
module tone_gen
    import tone_gen_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEFAULT
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic [DIV_W-1:0] div,
    output logic             tone,
    output logic             toggle,
    output logic             busy
);

    localparam logic [DIV_W-1:0] CntOne = {{(DIV_W-1){1'b0}}, 1'b1};

    state_e           state_q;
    logic [DIV_W-1:0] cnt_q;
    logic [DIV_W-1:0] act_div_q;
    logic             boundary;

    // act_div_q is never 0 outside idle, so the subtraction cannot wrap in use.
    assign boundary = (cnt_q == act_div_q - CntOne);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            act_div_q <= '0;
            tone      <= 1'b0;
            toggle    <= 1'b0;
            busy      <= 1'b0;
        end else begin
            toggle <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    cnt_q <= '0;
                    tone  <= 1'b0;
                    if (en && (div != '0)) begin
                        act_div_q <= div;
                        state_q   <= StRun;
                        busy      <= 1'b1;
                    end
                end
                StRun, StStop: begin
                    if (boundary) begin
                        cnt_q <= '0;
                        if ((state_q == StRun) && en && (div != '0)) begin
                            tone      <= ~tone;
                            toggle    <= 1'b1;
                            act_div_q <= div;
                        end else begin
                            // Ending a note: only a falling edge counts as a toggle.
                            tone    <= 1'b0;
                            toggle  <= tone;
                            state_q <= StIdle;
                            busy    <= 1'b0;
                        end
                    end else begin
                        cnt_q <= cnt_q + CntOne;
                        if ((state_q == StRun) && !en) begin
                            state_q <= StStop;
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                    cnt_q   <= '0;
                    tone    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tone_gen.sv
// Directed self-checking bench for tone_gen; outputs sampled on the falling clk edge.
module tb_tone_gen;

    localparam int unsigned DIV_W = 16;

    logic             clk = 1'b0;
    logic             rstn;
    logic             en;
    logic [DIV_W-1:0] div;
    logic             tone;
    logic             toggle;
    logic             busy;

    int checks = 0;
    int errors = 0;

    tone_gen #(.DIV_W(DIV_W)) dut (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .div    (div),
        .tone   (tone),
        .toggle (toggle),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    // Clean restart; returns at a falling edge with reset released.
    task automatic apply_reset();
        @(negedge clk);
        rstn = 1'b0;
        en   = 1'b0;
        div  = '0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    // Requests a note; returns at the falling edge after the RUN-entry edge (k=0).
    task automatic start_note(input logic [DIV_W-1:0] d);
        en  = 1'b1;
        div = d;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        en   = 1'b1;
        div  = 16'd3;
        #2 rstn = 1'b0;
        #1;
        checks++;
        if ({tone, toggle, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_async: tone/toggle/busy=%b%b%b exp 000", tone, toggle, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if ({tone, toggle, busy} !== 3'b000) begin
                errors++;
                $display("FAIL reset_hold cyc %0d: tone/toggle/busy=%b%b%b exp 000",
                         i, tone, toggle, busy);
            end
        end
        rstn = 1'b1;
        en   = 1'b0;
        div  = '0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic exp_tone;
        logic exp_tog;
        apply_reset();
        start_note(16'd3);
        checks++;
        if ({tone, toggle, busy} !== 3'b001) begin
            errors++;
            $display("FAIL basic entry: tone/toggle/busy=%b%b%b exp 001", tone, toggle, busy);
        end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_tone = ((k / 3) % 2) == 1;
            exp_tog  = (k % 3) == 0;
            checks++;
            if ({tone, toggle, busy} !== {exp_tone, exp_tog, 1'b1}) begin
                errors++;
                $display("FAIL basic k=%0d: tone/toggle/busy=%b%b%b exp %b%b1",
                         k, tone, toggle, busy, exp_tone, exp_tog);
            end
        end
    endtask

    task automatic test_div_change();
        logic exp_tone;
        logic exp_tog;
        apply_reset();
        start_note(16'd3);
        for (int k = 1; k <= 14; k++) begin
            @(negedge clk);
            if (k == 1) div = 16'd5;
            // Half 1: 3 cycles at old div; later halves 5 cycles each.
            exp_tone = (k >= 3 && k <= 7) || (k >= 13);
            exp_tog  = (k == 3) || (k == 8) || (k == 13);
            checks++;
            if ({tone, toggle} !== {exp_tone, exp_tog}) begin
                errors++;
                $display("FAIL div_change k=%0d: tone/toggle=%b%b exp %b%b",
                         k, tone, toggle, exp_tone, exp_tog);
            end
        end
    endtask

    task automatic test_stop();
        apply_reset();
        start_note(16'd4);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        checks++;
        if ({tone, toggle} !== 2'b11) begin
            errors++;
            $display("FAIL stop rise k=4: tone/toggle=%b%b exp 11", tone, toggle);
        end
        en = 1'b0;
        for (int k = 5; k <= 7; k++) begin
            @(negedge clk);
            if (k == 6) en = 1'b1;
            checks++;
            if ({tone, toggle, busy} !== 3'b101) begin
                errors++;
                $display("FAIL stop hold k=%0d: tone/toggle/busy=%b%b%b exp 101",
                         k, tone, toggle, busy);
            end
        end
        @(negedge clk);
        checks++;
        if ({tone, toggle, busy} !== 3'b010) begin
            errors++;
            $display("FAIL stop end k=8: tone/toggle/busy=%b%b%b exp 010", tone, toggle, busy);
        end
        // en still high and div=4: restart proceeds only through idle.
        @(negedge clk);
        checks++;
        if ({tone, toggle, busy} !== 3'b001) begin
            errors++;
            $display("FAIL stop restart k=9: tone/toggle/busy=%b%b%b exp 001", tone, toggle, busy);
        end
    endtask

    task automatic test_rest_min();
        apply_reset();
        en  = 1'b1;
        div = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({tone, toggle, busy} !== 3'b000) begin
                errors++;
                $display("FAIL rest cyc %0d: tone/toggle/busy=%b%b%b exp 000",
                         i, tone, toggle, busy);
            end
        end
        start_note(16'd1);
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            checks++;
            if ({tone, toggle, busy} !== {logic'(k % 2), 1'b1, 1'b1}) begin
                errors++;
                $display("FAIL min_div k=%0d: tone/toggle/busy=%b%b%b exp %0d11",
                         k, tone, toggle, busy, k % 2);
            end
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        start_note(16'd3);
        for (int k = 1; k <= 4; k++) @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        checks++;
        if ({tone, toggle, busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_mid async: tone/toggle/busy=%b%b%b exp 000", tone, toggle, busy);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (toggle !== 1'b0 || tone !== 1'b0) begin
                errors++;
                $display("FAIL reset_mid hold %0d: tone/toggle=%b%b exp 00", i, tone, toggle);
            end
        end
        rstn = 1'b1;
        @(negedge clk);
        checks++;
        if ({tone, toggle, busy} !== 3'b001) begin
            errors++;
            $display("FAIL reset_release entry: tone/toggle/busy=%b%b%b exp 001",
                     tone, toggle, busy);
        end
    endtask

    task automatic test_max_div();
        int k;
        apply_reset();
        start_note(16'hFFFF);
        k = 0;
        while (tone === 1'b0 && k < 70000) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 65535) begin
            errors++;
            $display("FAIL max_div half-period: measured %0d exp 65535", k);
        end
        checks++;
        if ({tone, toggle, busy} !== 3'b111) begin
            errors++;
            $display("FAIL max_div rise: tone/toggle/busy=%b%b%b exp 111", tone, toggle, busy);
        end
    endtask

    initial begin
        rstn = 1'b1;
        en   = 1'b0;
        div  = '0;
        test_reset();
        test_basic();
        test_div_change();
        test_stop();
        test_rest_min();
        test_reset_mid();
        test_max_div();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
